// File: rtl/delivery_game_uc_pkg.sv
// Shared definitions for the delivery game control unit: state codes also used by
// the top-level debug display decoder.
package delivery_game_uc_pkg;

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_PREPARA       = 4'd1,
    S_MEDE          = 4'd2,
    S_ESPERA_MEDIDA = 4'd3,
    S_JOGANDO       = 4'd4,
    S_PAUSA         = 4'd5,
    S_FIM_PERDEU    = 4'd6,
    S_FIM_GANHOU    = 4'd7
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100;
  localparam int unsigned DEFAULT_WIN_SCORE      = 7;

endpackage

// File: rtl/delivery_game_uc_if.sv
// Control-unit <-> datapath/buttons bundle. master = control unit, slave = its environment.
interface delivery_game_uc_if;

  logic       iniciar;
  logic       pausar;
  logic       game_over;
  logic [2:0] pontuacao;
  logic       velocity_ready;
  logic       end_delay;

  logic       zera;
  logic       count_map;
  logic       get_velocity;
  logic       reset_delay;
  logic       conta_delay;
  logic       jogando;
  logic       ganhou;
  logic       perdeu;
  logic       timeout_medida;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, pausar, game_over, pontuacao, velocity_ready, end_delay,
    output zera, count_map, get_velocity, reset_delay, conta_delay,
           jogando, ganhou, perdeu, timeout_medida, db_estado
  );

  modport slave (
    output iniciar, pausar, game_over, pontuacao, velocity_ready, end_delay,
    input  zera, count_map, get_velocity, reset_delay, conta_delay,
           jogando, ganhou, perdeu, timeout_medida, db_estado
  );

endinterface

// File: rtl/delivery_game_uc_edge.sv
// Rising-edge detector: one-cycle pulse per low-to-high transition of a raw button level.
module delivery_game_uc_edge (
  input  logic clk,
  input  logic reset_i,
  input  logic sinal_i,
  output logic pulso_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) prev_q <= 1'b0;
    else         prev_q <= sinal_i;
  end

  assign pulso_o = sinal_i & ~prev_q;

endmodule

// File: rtl/delivery_game_uc.sv
// Moore control unit for the delivery game: sequences the datapath through measure,
// play, pause and end-of-game states. All outputs are registered from the next state.
module delivery_game_uc
  import delivery_game_uc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned WIN_SCORE      = DEFAULT_WIN_SCORE
) (
  input  logic               clock,
  input  logic               reset,
  delivery_game_uc_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic iniciar_p;
  logic pausar_p;

  delivery_game_uc_edge u_edge_iniciar (
    .clk     (clock),
    .reset_i (~reset),
    .sinal_i (bus.iniciar),
    .pulso_o (iniciar_p)
  );

  delivery_game_uc_edge u_edge_pausar (
    .clk     (clock),
    .reset_i (~reset),
    .sinal_i (bus.pausar),
    .pulso_o (pausar_p)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  logic          win;
  logic          set_timeout;

  logic zera_q, count_map_q, get_velocity_q, reset_delay_q, conta_delay_q;
  logic jogando_q, ganhou_q, perdeu_q, timeout_q;
  logic [3:0] db_estado_q;

  assign tmo_hit = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign win     = (32'(bus.pontuacao) >= WIN_SCORE);

  // A ready arriving in the timeout cycle wins, so the flag is only set without it.
  assign set_timeout = (state_q == S_ESPERA_MEDIDA) && !bus.game_over &&
                       !bus.velocity_ready && tmo_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:          if (iniciar_p) state_d = S_PREPARA;
      S_PREPARA:       state_d = S_MEDE;
      S_MEDE:          state_d = bus.game_over ? S_FIM_PERDEU : S_ESPERA_MEDIDA;
      S_ESPERA_MEDIDA: begin
        if (bus.game_over)                     state_d = S_FIM_PERDEU;
        else if (bus.velocity_ready || tmo_hit) state_d = S_JOGANDO;
      end
      S_JOGANDO: begin
        if (bus.game_over)      state_d = S_FIM_PERDEU;
        else if (win)           state_d = S_FIM_GANHOU;
        else if (pausar_p)      state_d = S_PAUSA;
        else if (bus.end_delay) state_d = S_MEDE;
      end
      S_PAUSA: begin
        if (iniciar_p)     state_d = S_PREPARA;
        else if (pausar_p) state_d = S_JOGANDO;
      end
      S_FIM_PERDEU,
      S_FIM_GANHOU:    if (iniciar_p) state_d = S_PREPARA;
      default:         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_ESPERA_MEDIDA) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      tmo_cnt_q      <= '0;
      zera_q         <= 1'b0;
      count_map_q    <= 1'b0;
      get_velocity_q <= 1'b0;
      reset_delay_q  <= 1'b0;
      conta_delay_q  <= 1'b0;
      jogando_q      <= 1'b0;
      ganhou_q       <= 1'b0;
      perdeu_q       <= 1'b0;
      timeout_q      <= 1'b0;
      db_estado_q    <= '0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      zera_q         <= (state_d == S_PREPARA);
      count_map_q    <= (state_d == S_MEDE) || (state_d == S_ESPERA_MEDIDA) ||
                        (state_d == S_JOGANDO);
      get_velocity_q <= (state_d == S_MEDE);
      reset_delay_q  <= (state_d == S_PREPARA) || (state_d == S_MEDE);
      conta_delay_q  <= (state_d == S_JOGANDO);
      jogando_q      <= (state_d == S_JOGANDO);
      ganhou_q       <= (state_d == S_FIM_GANHOU);
      perdeu_q       <= (state_d == S_FIM_PERDEU);
      timeout_q      <= (state_d == S_PREPARA) ? 1'b0 : (timeout_q | set_timeout);
      db_estado_q    <= state_d;
    end
  end

  assign bus.zera           = zera_q;
  assign bus.count_map      = count_map_q;
  assign bus.get_velocity   = get_velocity_q;
  assign bus.reset_delay    = reset_delay_q;
  assign bus.conta_delay    = conta_delay_q;
  assign bus.jogando        = jogando_q;
  assign bus.ganhou         = ganhou_q;
  assign bus.perdeu         = perdeu_q;
  assign bus.timeout_medida = timeout_q;
  assign bus.db_estado      = db_estado_q;

endmodule
